// File: rtl/map_edit_scheduler.sv
// rtl/map_edit_scheduler.sv - queues map block edits and drains them, with a pose latch, in the inter-frame window
module map_edit_scheduler #(
    parameter int                 DEPTH      = 4,
    parameter int                 WIN_CYCLES = 64,
    parameter logic        [17:0] POS_X0     = 18'(170 << 8),
    parameter logic        [17:0] POS_Y0     = 18'(170 << 8),
    parameter logic        [17:0] POS_Z0     = 18'(280 << 8),
    parameter logic signed [19:0] ANG_X0     = 20'sd30,
    parameter logic signed [19:0] ANG_Y0     = -20'sd120
) (
    input  logic                      PPL_clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [14:0]               req_addr,
    input  logic [4:0]                req_data,
    input  logic                      vs,
    input  logic                      valid,
    input  logic [17:0]               pose_x,
    input  logic [17:0]               pose_y,
    input  logic [17:0]               pose_z,
    input  logic signed [19:0]        ang_x,
    input  logic signed [19:0]        ang_y,
    output logic [17:0]               p_pos_x,
    output logic [17:0]               p_pos_y,
    output logic [17:0]               p_pos_z,
    output logic signed [19:0]        p_angle_x,
    output logic signed [19:0]        p_angle_y,
    output logic                      write_en,
    output logic [14:0]               write_addr,
    output logic [4:0]                write_data,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      window
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(WIN_CYCLES + 1);
    localparam logic [AW:0]   FULL     = DEPTH[AW:0];
    localparam logic [WW-1:0] WIN_LOAD = WIN_CYCLES[WW-1:0];

    typedef enum logic {RUN, DRAIN} state_t;

    logic [19:0]        mem [DEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [WW-1:0]      wcnt_q, wcnt_d;
    state_t             state_q, state_d;
    logic               write_en_q, write_en_d, window_q, window_d;
    logic [14:0]        write_addr_q, write_addr_d;
    logic [4:0]         write_data_q, write_data_d;
    logic [17:0]        px_q, px_d, py_q, py_d, pz_q, pz_d;
    logic signed [19:0] ax_q, ax_d, ay_q, ay_d;
    logic               push, pop;

    assign req_ready = (count_q != FULL);

    always_comb begin
        push         = req_valid && req_ready;
        // Render traffic in flight blocks the pop outright; the exit below handles the abort.
        pop          = (state_q == DRAIN) && (count_q != '0) && !valid && (wcnt_q != '0);
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        px_d         = px_q;
        py_d         = py_q;
        pz_d         = pz_q;
        ax_d         = ax_q;
        ay_d         = ay_q;
        if (vs) begin
            state_d = DRAIN;
            wcnt_d  = WIN_LOAD;
            px_d    = pose_x;
            py_d    = pose_y;
            pz_d    = pose_z;
            ax_d    = ang_x;
            ay_d    = ang_y;
        end else if (state_q == DRAIN) begin
            if (pop) begin
                wcnt_d = wcnt_q - 1'b1;
                if (wcnt_q == WW'(1)) state_d = RUN;
            end else begin
                state_d = RUN;
            end
        end
        window_d     = (state_d == DRAIN);
        write_en_d   = pop;
        write_addr_d = pop ? mem[rd_ptr_q][19:5] : write_addr_q;
        write_data_d = pop ? mem[rd_ptr_q][4:0] : write_data_q;
    end

    always_ff @(posedge PPL_clk) begin
        if (push) mem[wr_ptr_q] <= {req_addr, req_data};
    end

    always_ff @(posedge PPL_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wcnt_q       <= '0;
            state_q      <= RUN;
            window_q     <= 1'b0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            px_q         <= POS_X0;
            py_q         <= POS_Y0;
            pz_q         <= POS_Z0;
            ax_q         <= ANG_X0;
            ay_q         <= ANG_Y0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wcnt_q       <= wcnt_d;
            state_q      <= state_d;
            window_q     <= window_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            px_q         <= px_d;
            py_q         <= py_d;
            pz_q         <= pz_d;
            ax_q         <= ax_d;
            ay_q         <= ay_d;
        end
    end

    assign write_en   = write_en_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign window     = window_q;
    assign pending    = count_q;
    assign p_pos_x    = px_q;
    assign p_pos_y    = py_q;
    assign p_pos_z    = pz_q;
    assign p_angle_x  = ax_q;
    assign p_angle_y  = ay_q;
endmodule
